// File: rtl/mdu_hilo_unit.sv
// rtl/mdu_hilo_unit.sv - iterative multiply/divide unit owning the HI/LO registers
//
// Executes mult/multu (radix-2 shift-add) and div/divu (restoring shift-subtract)
// over WIDTH iterations plus one sign-fix cycle. It also performs mthi/mtlo
// writes directly.
//
// Optional feature macro: MDU_EARLY_OUT_EN. When defined, a multiply with a zero
// operand, or a divide by zero, skips the iteration phase.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         issue strobe and opcode
//                     (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, other none)
//   busA, busB        rs / rt operands
//   kill              pipeline flush, aborts an in-flight mult/div
//   busy              mult/div in progress (CALC or FIX)
//   done              one-cycle pulse after HI/LO writeback of a mult/div
//   hi, lo            HI/LO registers

module mdu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {partial product high, multiplier shifting out at bit 0}.
    // Divide:   {partial remainder, dividend shifting in / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;    // negate product / quotient
    logic               neg_r;    // negate remainder

    // Issue-time operand decode
    logic             signed_op, a_neg, b_neg, op_div;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_neg     = signed_op & busA[WIDTH-1];
    assign b_neg     = signed_op & busB[WIDTH-1];
    // -0x80000000 wraps to itself, which is the correct unsigned magnitude
    assign a_mag     = a_neg ? -busA : busA;
    assign b_mag     = b_neg ? -busB : busB;

    // One multiply step: conditionally add, then shift the 2W+1 bit result right
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] mul_next;
    assign psum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcd} : '0);
    assign mul_next = {psum, acc[WIDTH-1:1]};

    // One restoring divide step; the borrow bit of the trial subtraction
    // decides the quotient bit
    logic [WIDTH:0]     trial, tdiff;
    logic               ge;
    logic [2*WIDTH-1:0] div_next;
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign tdiff    = trial - {1'b0, mcd};
    assign ge       = ~tdiff[WIDTH];
    assign div_next = {(ge ? tdiff[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};

    logic [WIDTH-1:0] rem_mag, quo_mag;
    assign rem_mag = acc[2*WIDTH-1:WIDTH];
    assign quo_mag = acc[WIDTH-1:0];

`ifdef MDU_EARLY_OUT_EN
    logic early;
    assign early = op_div ? (busB == '0) : ((busA == '0) || (busB == '0));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcd    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    is_div <= op_div;
                                    neg_q  <= a_neg ^ b_neg;
                                    neg_r  <= a_neg;
                                    mcd    <= op_div ? b_mag : a_mag;
                                    acc    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                                    cnt    <= CNT_W'(WIDTH - 1);
                                    busy   <= 1'b1;
                                    state  <= CALC;
`ifdef MDU_EARLY_OUT_EN
                                    if (early) begin
                                        // Final magnitudes: product 0, or
                                        // divide-by-zero quotient all ones, remainder |A|
                                        acc   <= op_div ? {a_mag, {WIDTH{1'b1}}} : '0;
                                        state <= FIX;
                                    end
`endif
                                end
                                OP_MTHI: hi <= busA;
                                OP_MTLO: lo <= busA;
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        if (cnt == '0)
                            state <= FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                    FIX: begin
                        if (is_div) begin
                            hi <= neg_r ? -rem_mag : rem_mag;
                            lo <= neg_q ? -quo_mag : quo_mag;
                        end else begin
                            {hi, lo} <= neg_q ? -acc : acc;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// tb/tb_mdu_hilo_unit.sv - scoreboard testbench for mdu_hilo_unit
module tb_mdu_hilo_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] busA, busB;
    logic        kill;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    logic [63:0] sbq[$];
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .busA(busA), .busB(busB), .kill(kill),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {hi,lo} from plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (o)
            3'd1: begin p = longint'(sa) * longint'(sb); return p; end
            3'd2: begin up = {32'd0, a} * {32'd0, b}; return up; end
            3'd3: begin
                if (b == 0) return {a, (sa < 0) ? 32'h00000001 : 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd4: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return {m_hi, m_lo};
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if ((o == 3'd3 || o == 3'd4) && b == 0) return 1;
        if ((o == 3'd1 || o == 3'd2) && (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h with no operation outstanding", hi, lo);
            end else begin
                logic [63:0] e;
                e = sbq.pop_front();
                if ({hi, lo} !== e) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", {hi, lo}, e);
                end
            end
        end
    end

    // Drive one issue cycle; returns #1 after the sampling edge E0
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; busA = a; busB = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_done(input int lat, input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({name, "_latency"}, n, lat);
        chk({name, "_done"}, done, 1'b1);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string name);
        sbq.push_back(exp);
        issue(o, a, b);
        wait_done(exp_lat(o, a, b), name);
        {m_hi, m_lo} = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; busA = '0; busB = '0; kill = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hilo", {hi, lo}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd1, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE}, "mult_m1x2");
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'hFFFFFFFE}, "multu_ffx2");
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7d2");
        run_op(3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100d7");
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, "div_ovf");
        run_op(3'd3, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'h00000001}, "div_neg_by0");
        run_op(3'd3, 32'd7, 32'd0, {32'd7, 32'hFFFFFFFF}, "div_pos_by0");
        run_op(3'd1, 32'd0, 32'd9, 64'h0, "mult_0x9");

        // mthi then mtlo on consecutive cycles
        start = 1'b1; op = 3'd5; busA = 32'h12345678;
        @(posedge clk); #1;
        chk("mthi_hi", hi, 32'h12345678);
        op = 3'd6; busA = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mthi_hi_kept", hi, 32'h12345678);
        chk("mthilo_busy", busy, 1'b0);
        chk("mthilo_done", done, 1'b0);
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

        // mthi issued while a mult is busy is ignored
        sbq.push_back({32'h0, 32'd42});
        issue(3'd1, 32'd6, 32'd7);
        start = 1'b1; op = 3'd5; busA = 32'hDEADBEEF;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        chk("busy_ign_hi", hi, m_hi);
        wait_done(32, "busy_ign");
        m_hi = 32'h0; m_lo = 32'd42;

        // kill mid-CALC: no writeback, no done
        issue(3'd1, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_busy", busy, 1'b0);
        chk("kill_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (40) @(posedge clk);
        #1;
        chk("kill_hilo_late", {hi, lo}, {m_hi, m_lo});
        run_op(3'd4, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, "divu_5d0");

        // kill together with start in IDLE: kill wins
        kill = 1'b1;
        issue(3'd5, 32'h11111111, 32'h0);
        kill = 1'b0;
        chk("kill_start_hi", hi, m_hi);
        chk("kill_start_busy", busy, 1'b0);

        // randomized operations, issued back to back
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, ref_model(ro, ra, rb), "rand");
        end

        // asynchronous reset mid-CALC clears everything immediately
        sbq.push_back(ref_model(3'd1, 32'd1234, 32'd5678));
        issue(3'd1, 32'd1234, 32'd5678);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_hilo", {hi, lo}, 64'h0);
        sbq.delete();
        m_hi = '0; m_lo = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_op(3'd1, 32'd0, 32'd9, 64'h0, "mult_0x9_post");

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO architectural registers of the 5-stage MIPS pipeline.
- Executes the mult, multu, div, divu, mthi and mtlo operations issued by the ID-stage control decoder.
- Exposes HI/LO for mfhi/mflo.
- Raises busy so the hazard unit can stall a dependent mfhi/mflo or a following mult/div.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; holds WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue strobe; op/busA/busB are valid in this cycle.
- op  in  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=none.
- busA  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source.
- busB  in  WIDTH  rt operand: multiplier or divisor.
- kill  in  1  pipeline flush; aborts any in-flight mult/div.
- busy  out  1  mult/div in progress.
- done  out  1  one-cycle pulse; HI/LO have just been updated by a mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Counter and working registers cleared.
  - An in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX.
- busy is 1 exactly when state is CALC or FIX.
- IDLE, start=1 with op 1-4:
  - Latch operand magnitudes (absolute values for the signed ops), result sign flags and the op type.
  - Counter=WIDTH-1; go to CALC.
- IDLE, start=1 with op 5 (mthi): hi<=busA at that edge; no busy, no done.
- IDLE, start=1 with op 6 (mtlo): lo<=busA at that edge; no busy, no done.
- op 0 or 7 with start=1: no effect.
- CALC: one iteration per cycle.
  - Multiply: shift-add radix-2 into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - When counter reaches 0, go to FIX; otherwise decrement the counter.
- FIX: apply sign correction.
  - mult: the 64-bit product is negated if the sign of busA differs from the sign of busB.
  - div: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - At the edge leaving FIX, {hi,lo} are written and the FSM goes to IDLE.
  - Mult writes {hi,lo}=product. Div/divu writes hi=remainder, lo=quotient.
- Latency (start sampled at edge E0):
  - busy=1 during cycles E0+1..E0+33 (32 CALC cycles + 1 FIX cycle).
  - New hi/lo and done=1 are visible in cycle E0+34, where busy=0.
- done: registered; high for exactly one cycle after each mult/div writeback; never high for mthi/mtlo.
- start while busy: ignored, including ops 5 and 6. The hazard unit must hold issue; the bench checks that state is unchanged.
- start in the same cycle that busy falls (IDLE reached): accepted normally; back-to-back issue is allowed.
- kill=1: FSM goes to IDLE at the next edge and hi/lo are unchanged. If kill and start occur together in IDLE, kill wins.
- Divide by zero (busB=0): defined, no trap.
  - divu: lo=32'hFFFFFFFF, hi=busA.
  - div: lo=32'hFFFFFFFF if busA>=0, else 32'h00000001; hi=busA.
- Signed overflow case div 0x80000000 / -1: lo=0x80000000, hi=0.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned inside the datapath.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - In IDLE on mult/multu with busA==0 or busB==0, or div/divu with busB==0, the FSM skips CALC and goes straight to FIX.
  - FIX loads the final result directly.
  - busy is high for 1 cycle; hi/lo and done are visible at E0+2.
- Not defined: every mult/div takes the full 34-cycle latency; results are identical either way.

Test Plan:
- Reset, then op=1 (mult) busA=0xFFFFFFFF (-1), busB=2 -> busy for 33 cycles; at E0+34 hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
- op=2 (multu) with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- op=3 (div) busA=-7 (0xFFFFFFF9), busB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); op=4 (divu) busA=100, busB=7 -> lo=14, hi=2.
- op=5 busA=0x12345678, then op=6 busA=0x9ABCDEF0 on consecutive cycles -> hi/lo updated next edge, busy and done stay 0; a further start op=5 issued during a busy mult leaves hi unchanged.
- Start mult 3*5, assert kill at E0+10 -> busy drops at E0+11, hi/lo keep their prior values, no done; a divu 5/0 issued afterwards -> lo=0xFFFFFFFF, hi=5.
- Assert rst_n=0 mid-CALC -> busy, done, hi and lo all 0 immediately; with MDU_EARLY_OUT_EN defined, mult 0*9 -> done at E0+2, hi=lo=0.
